// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: sequencer states, bus owner and counter widths.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  typedef enum logic {
    OwnCpu,
    OwnVid
  } owner_e;

  localparam int unsigned WcntW   = 3;
  localparam int unsigned StreakW = 4;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter for one asynchronous SRAM: fixed video priority with a CPU starvation guard,
// wait-state strobe sequencing and registered strobes, data and acks.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned WAIT_STATES    = 1,
  parameter int unsigned VID_STREAK_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [StreakW-1:0] StreakMax = StreakW'(VID_STREAK_MAX);
  localparam logic [WcntW-1:0]   WcntInit  = WcntW'(WAIT_STATES);

  state_e               state_q;
  owner_e               owner_q;
  logic                 we_q;
  logic [WcntW-1:0]     wcnt_q;
  logic [StreakW-1:0]   streak_q;

  logic vid_win, cpu_win, grant, grant_we;

  // Video wins ties unless it has already taken StreakMax grants while the CPU waited.
  assign vid_win  = vid_req && !(cpu_req && (streak_q == StreakMax));
  assign cpu_win  = cpu_req && !vid_win;
  assign grant    = vid_win || cpu_win;
  assign grant_we = cpu_win && cpu_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= OwnCpu;
      we_q        <= 1'b0;
      wcnt_q      <= '0;
      streak_q    <= '0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vid_rdata   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      cpu_ack <= 1'b0;
      vid_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // vid_win implies streak_q < StreakMax whenever cpu_req is high, so no overflow.
          if (vid_win) streak_q <= cpu_req ? streak_q + 1'b1 : '0;
          else         streak_q <= '0;
          if (grant) begin
            state_q    <= StAccess;
            owner_q    <= vid_win ? OwnVid : OwnCpu;
            we_q       <= grant_we;
            wcnt_q     <= WcntInit;
            sram_addr  <= vid_win ? vid_addr : cpu_addr;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= grant_we;
            sram_we_n  <= !grant_we;
            sram_dq_oe <= grant_we;
            if (grant_we) sram_dq_out <= cpu_wdata;
          end
        end
        StAccess: begin
          if (wcnt_q == '0) begin
            state_q   <= StDone;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (owner_q == OwnVid) begin
              vid_ack   <= 1'b1;
              vid_rdata <= sram_dq_in;
            end else begin
              cpu_ack <= 1'b1;
              if (!we_q) cpu_rdata <= sram_dq_in;
            end
          end else begin
            wcnt_q <= wcnt_q - 1'b1;
          end
        end
        StDone: begin
          // Write data stays driven through DONE for hold; the next IDLE is the turnaround.
          state_q    <= StIdle;
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised and directed bench for sram_arbiter with a cycle-position reference model.
module tb_sram_arbiter;

  localparam int unsigned WS   = 1;
  localparam int unsigned SMAX = 3;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_ack, vid_req, vid_ack;
  logic [18:0] cpu_addr, vid_addr, sram_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, vid_rdata, sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  logic        cpu_req0, cpu_we0, cpu_ack0, vid_req0, vid_ack0;
  logic [18:0] cpu_addr0, vid_addr0, sram_addr0;
  logic [7:0]  cpu_wdata0, cpu_rdata0, vid_rdata0, sram_dq_out0, sram_dq_in0;
  logic        sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0;

  int n_checks = 0;
  int n_fail   = 0;
  int contention0 = 0;

  logic [7:0] pad_mem [0:524287];
  logic [7:0] ref_mem [0:524287];

  sram_arbiter #(.ADDR_W(19), .DATA_W(8), .WAIT_STATES(WS), .VID_STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_arbiter #(.ADDR_W(19), .DATA_W(8), .WAIT_STATES(0), .VID_STREAK_MAX(SMAX)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req0), .cpu_we(cpu_we0), .cpu_addr(cpu_addr0), .cpu_wdata(cpu_wdata0),
    .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
    .vid_req(vid_req0), .vid_addr(vid_addr0), .vid_ack(vid_ack0), .vid_rdata(vid_rdata0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
    .sram_dq_in(sram_dq_in0), .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0),
    .sram_we_n(sram_we_n0)
  );

  // Pad returns inverted data whenever the read strobes are not both asserted.
  assign sram_dq_in  = (!sram_ce_n && !sram_oe_n) ? pad_mem[sram_addr] : ~pad_mem[sram_addr];
  assign sram_dq_in0 = (!sram_ce_n0 && !sram_oe_n0) ? (sram_addr0[7:0] ^ 8'h5A)
                                                     : ~(sram_addr0[7:0] ^ 8'h5A);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int unsigned a);
    return 8'((a * 29) ^ (a >> 11));
  endfunction

  // SRAM pad: writes land at the edge closing a cycle with we_n low.
  initial forever begin
    @(posedge clk);
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) pad_mem[sram_addr] = sram_dq_out;
  end

  // Reference model: a transaction occupies positions 1..WS+2 after its grant edge;
  // strobes for 1..WS+1, ack at WS+2, idle turnaround afterwards.
  bit          m_busy = 0, m_vid = 0, m_we = 0;
  int          m_pos = 0, m_streak = 0;
  logic [18:0] m_addr = '0, e_addr = '0;
  logic [7:0]  m_wdata = '0, e_dqo = '0, e_crd = '0, e_vrd = '0;

  initial forever begin
    @(negedge clk);
    if (!sram_oe_n0 && sram_dq_oe0) contention0++;
    if (!rst_n) begin
      m_busy = 0; m_pos = 0; m_streak = 0;
      e_addr = '0; e_dqo = '0; e_crd = '0; e_vrd = '0;
    end else begin
      bit strobe, ack_now;
      ack_now = m_busy && (m_pos == WS + 2);
      strobe  = m_busy && (m_pos <= WS + 1);
      if (ack_now && !m_we) begin
        if (m_vid) e_vrd = ref_mem[m_addr];
        else       e_crd = ref_mem[m_addr];
      end
      if (ack_now && m_we) ref_mem[m_addr] = m_wdata;
      chk("ce_n", sram_ce_n, !m_busy);
      chk("oe_n", sram_oe_n, !(strobe && !m_we));
      chk("we_n", sram_we_n, !(strobe && m_we));
      chk("dq_oe", sram_dq_oe, m_busy && m_we);
      chk("cpu_ack", cpu_ack, ack_now && !m_vid);
      chk("vid_ack", vid_ack, ack_now && m_vid);
      chk("cpu_rdata", cpu_rdata, e_crd);
      chk("vid_rdata", vid_rdata, e_vrd);
      chk("sram_addr", sram_addr, e_addr);
      chk("dq_out", sram_dq_out, e_dqo);
      chk("bus_contention", !sram_oe_n && sram_dq_oe, 0);
      if (m_busy) begin
        if (ack_now) m_busy = 0;
        else         m_pos++;
      end else begin
        bit gv, gc;
        gv = vid_req && !(cpu_req && m_streak == SMAX);
        gc = cpu_req && !gv;
        if (gv) m_streak = cpu_req ? ((m_streak < SMAX) ? m_streak + 1 : SMAX) : 0;
        else    m_streak = 0;
        if (gv) begin
          m_vid = 1; m_we = 0; m_addr = vid_addr;
        end else if (gc) begin
          m_vid = 0; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
        end
        if (gv || gc) begin
          m_busy = 1; m_pos = 1; e_addr = m_addr;
          if (m_we) e_dqo = m_wdata;
        end
      end
    end
  end

  task automatic do_op(input bit vid, input bit we, input logic [18:0] a, input logic [7:0] d,
                       output int lat, output int we_lo, output int oe_lo, output int dqoe_hi,
                       output logic [7:0] rd);
    lat = -1; we_lo = 0; oe_lo = 0; dqoe_hi = 0; rd = '0;
    @(posedge clk); #1;
    if (vid) begin vid_req = 1; vid_addr = a; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (!sram_we_n) we_lo++;
      if (!sram_oe_n) oe_lo++;
      if (sram_dq_oe) dqoe_hi++;
      if (vid ? vid_ack : cpu_ack) begin
        lat = i; rd = vid ? vid_rdata : cpu_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    if (vid) vid_req = 0; else cpu_req = 0;
  endtask

  task automatic rand_req(input bit vid, input int n);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      int  gap;
      bit  got;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        if (vid) vid_req = 0; else cpu_req = 0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      if (vid) begin
        vid_addr = 19'($urandom_range(0, 15)); vid_req = 1;
      end else begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 19'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom); cpu_req = 1;
      end
      got = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (vid ? vid_ack : cpu_ack) begin got = 1; break; end
      end
      chk(vid ? "vid_rand_timeout" : "cpu_rand_timeout", got, 1);
      @(posedge clk); #1;
    end
    if (vid) vid_req = 0; else cpu_req = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, we_lo, oe_lo, dqoe_hi, cyc, na;
    logic [7:0] rd, pat;
    int tq[$];
    for (int a = 0; a < 524288; a++) begin
      pad_mem[a] = init_val(a);
      ref_mem[a] = init_val(a);
    end
    pad_mem[19'h7FFFF] = 8'h3C;
    ref_mem[19'h7FFFF] = 8'h3C;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; vid_req = 0; vid_addr = '0;
    cpu_req0 = 0; cpu_we0 = 0; cpu_addr0 = '0; cpu_wdata0 = '0; vid_req0 = 0; vid_addr0 = '0;
    rst_n = 1;
    #3 rst_n = 0;
    #4;
    chk("reset_ce_n", sram_ce_n, 1);
    chk("reset_oe_n", sram_oe_n, 1);
    chk("reset_we_n", sram_we_n, 1);
    chk("reset_dq_oe", sram_dq_oe, 0);
    chk("reset_acks", {cpu_ack, vid_ack}, 0);
    chk("reset_rdata", {cpu_rdata, vid_rdata}, 0);
    chk("reset_addr_dq", {sram_addr, sram_dq_out}, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    // Zero wait states: read latency 2, access period 3.
    @(posedge clk); #1;
    cpu_req0 = 1; cpu_addr0 = 19'h11;
    lat = -1; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (cpu_ack0) begin lat = i; rd = cpu_rdata0; break; end
    end
    chk("ws0_cpu_latency", lat, 2);
    chk("ws0_cpu_rdata", rd, 8'h4B);
    @(posedge clk); #1 cpu_req0 = 0;
    @(posedge clk); #1;
    vid_req0 = 1; vid_addr0 = 19'h22;
    cyc = 0; tq.delete();
    while (tq.size() < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (vid_ack0) begin tq.push_back(cyc); rd = vid_rdata0; end
    end
    @(posedge clk); #1 vid_req0 = 0;
    chk("ws0_vid_ack_count", tq.size(), 4);
    if (tq.size() == 4) begin
      chk("ws0_vid_first_ack", tq[0], 3);
      chk("ws0_vid_period_a", tq[1] - tq[0], 3);
      chk("ws0_vid_period_b", tq[3] - tq[2], 3);
    end
    chk("ws0_vid_rdata", rd, 8'h78);

    // CPU write then read-back.
    do_op(0, 1, 19'h00123, 8'hA5, lat, we_lo, oe_lo, dqoe_hi, rd);
    chk("wr_latency", lat, 3);
    chk("wr_we_low_cycles", we_lo, 2);
    chk("wr_dq_oe_cycles", dqoe_hi, 3);
    chk("wr_oe_low_cycles", oe_lo, 0);
    do_op(0, 0, 19'h00123, 8'h00, lat, we_lo, oe_lo, dqoe_hi, rd);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd, 8'hA5);
    chk("rd_oe_low_cycles", oe_lo, 2);

    // Video read of the preloaded top word.
    do_op(1, 0, 19'h7FFFF, 8'h00, lat, we_lo, oe_lo, dqoe_hi, rd);
    chk("vid_latency", lat, 3);
    chk("vid_rdata_top", rd, 8'h3C);
    chk("vid_oe_low_cycles", oe_lo, 2);
    chk("vid_dq_oe_cycles", dqoe_hi, 0);

    // Both held: V,V,V,C repeating, CPU served every 16 cycles.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00123; vid_req = 1; vid_addr = 19'h7FFFF;
    cyc = 0; na = 0; pat = '0; tq.delete();
    while (na < 8 && cyc < 300) begin
      @(negedge clk); cyc++;
      if (vid_ack && na < 8) begin pat[na] = 1'b1; na++; end
      if (cpu_ack && na < 8) begin pat[na] = 1'b0; tq.push_back(cyc); na++; end
    end
    @(posedge clk); #1;
    cpu_req = 0; vid_req = 0;
    chk("both_grant_count", na, 8);
    chk("both_grant_order", pat, 8'b0111_0111);
    chk("both_cpu_acks", tq.size(), 2);
    if (tq.size() == 2) begin
      chk("both_first_cpu_ack", tq[0], 16);
      chk("both_cpu_spacing", tq[1] - tq[0], 16);
    end

    // Video alone: back-to-back every 4 cycles, streak never builds.
    @(posedge clk); #1;
    vid_req = 1; vid_addr = 19'h00123;
    cyc = 0; tq.delete();
    while (tq.size() < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (vid_ack) tq.push_back(cyc);
    end
    chk("vid_alone_streak", 32'(dut.streak_q), 0);
    @(posedge clk); #1 vid_req = 0;
    chk("vid_alone_acks", tq.size(), 5);
    if (tq.size() == 5) begin
      chk("vid_alone_first", tq[0], 4);
      chk("vid_alone_period_a", tq[1] - tq[0], 4);
      chk("vid_alone_period_b", tq[4] - tq[3], 4);
    end

    // Asynchronous reset in the middle of a CPU write's ACCESS phase.
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00200; cpu_wdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_we_n", sram_we_n, 0);
    #2 rst_n = 0;
    #1;
    chk("async_ce_n", sram_ce_n, 1);
    chk("async_we_n", sram_we_n, 1);
    chk("async_dq_oe", sram_dq_oe, 0);
    na = 0;
    repeat (3) begin @(negedge clk); if (cpu_ack) na++; end
    chk("reset_no_ack", na, 0);
    @(posedge clk); #2 rst_n = 1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (cpu_ack) begin lat = i; break; end
    end
    chk("post_reset_latency", lat, 3);
    @(posedge clk); #1 cpu_req = 0;
    do_op(0, 0, 19'h00200, 8'h00, lat, we_lo, oe_lo, dqoe_hi, rd);
    chk("post_reset_readback", rd, 8'h5A);

    // Randomised traffic from both ports against the model.
    fork
      rand_req(0, 60);
      rand_req(1, 60);
    join
    repeat (6) @(posedge clk);
    chk("ws0_bus_contention", contention0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
